// File: rtl/vga_capture.sv
// vga_capture: receive side of the TinyVGA PMOD bus. It recovers line and
// frame timing from hsync/vsync, tracks lock against the configured timing,
// and emits per-pixel coordinates, colour and per-frame statistics.
//
// Ports:
//   clk, rst_n           pixel clock, asynchronous active-low reset
//   vga_in[7:0]          PMOD word {hsync,B0,G0,R0,vsync,B1,G1,R1}
//   pix_x, pix_y         recovered column/row, valid while de
//   de                   active-video strobe, forced low unless locked
//   rgb[5:0]             {R1,R0,G1,G0,B1,B0}, valid while de
//   locked               timing lock status
//   frame_done           one-cycle pulse per vsync assertion edge
//   frame_lit            non-black active pixels in the last frame
//   err_cnt              saturating count of timing violations
//   frame_crc            CRC-16-CCITT of the last frame's pixels
//
// Build option: define VGA_CAPTURE_CRC_EN to build the frame CRC;
// otherwise frame_crc is tied to 0.

module vga_capture #(
    parameter int   H_DISPLAY   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_DISPLAY   = 480,
    parameter int   V_BOTTOM    = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_TOP       = 33,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_in,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        de,
    output logic [5:0]  rgb,
    output logic        locked,
    output logic        frame_done,
    output logic [18:0] frame_lit,
    output logic [7:0]  err_cnt,
    output logic [15:0] frame_crc
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
    localparam logic [11:0] H_LEN = 12'(H_TOTAL);
    localparam logic [9:0]  V_LEN = 10'(V_TOTAL);
    localparam logic [10:0] H_A0  = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_A1  = 11'(H_SYNC + H_BACK + H_DISPLAY);
    localparam logic [9:0]  V_A0  = 10'(V_SYNC + V_TOP);
    localparam logic [9:0]  V_A1  = 10'(V_SYNC + V_TOP + V_DISPLAY);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   good, good_nxt, good_inc;
    logic            frame_bad, bad_nxt;
    logic            err_hit;

    logic [7:0]  in_q, in_d;
    logic        h_edge, v_edge;
    logic [10:0] h_cnt, h_nxt;
    logic [9:0]  v_cnt, v_nxt;
    logic [11:0] line_len;
    logic        stuck;
    logic        in_win;
    logic [5:0]  col;
    logic [18:0] lit_cnt;

    // in_d is the previous sample of in_q; it also lines the colour up
    // with h_cnt/v_cnt, which describe the sample now held in in_d.
    assign h_edge = (in_d[7] != SYNC_ACTIVE) && (in_q[7] == SYNC_ACTIVE);
    assign v_edge = (in_d[3] != SYNC_ACTIVE) && (in_q[3] == SYNC_ACTIVE);
    assign col    = {in_d[0], in_d[4], in_d[1], in_d[5], in_d[2], in_d[6]};

    always_comb begin
        h_nxt = h_cnt;
        v_nxt = v_cnt;
        if (h_edge)
            h_nxt = '0;
        else if (h_cnt != 11'h7FF)
            h_nxt = h_cnt + 11'd1;
        if (v_edge)
            v_nxt = '0;
        else if (h_edge && v_cnt != 10'h3FF)
            v_nxt = v_cnt + 10'd1;
    end

    assign line_len = {1'b0, h_cnt} + 12'd1;
    // Flag only the cycle the counter first saturates, so a stuck sync
    // counts as a single violation.
    assign stuck    = (h_nxt == 11'h7FF) && (h_cnt != 11'h7FF);
    assign in_win   = (h_cnt >= H_A0) && (h_cnt < H_A1) &&
                      (v_cnt >= V_A0) && (v_cnt < V_A1);

    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        bad_nxt   = frame_bad;
        err_hit   = 1'b0;
        good_inc  = (good == GOOD_MAX) ? good : good + GW'(1);
        if (state == SEARCH) begin
            if (v_edge) begin
                state_nxt = TRACK;
                good_nxt  = '0;
                bad_nxt   = 1'b0;
            end
        end else begin
            err_hit = (h_edge && line_len != H_LEN) || stuck ||
                      (v_edge && v_cnt != V_LEN);
            if (err_hit) begin
                state_nxt = TRACK;
                good_nxt  = '0;
                bad_nxt   = 1'b1;
            end
            // A frame only counts as good if nothing went wrong since
            // the previous vsync edge.
            if (v_edge) begin
                bad_nxt = 1'b0;
                if (!err_hit && !frame_bad) begin
                    good_nxt = good_inc;
                    if (good_inc == GOOD_MAX)
                        state_nxt = LOCKED;
                end
            end
        end
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            good      <= '0;
            frame_bad <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            good      <= good_nxt;
            frame_bad <= bad_nxt;
            if (err_hit && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q  <= '0;
            in_d  <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            in_q  <= vga_in;
            in_d  <= in_q;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de    <= 1'b0;
            pix_x <= '0;
            pix_y <= '0;
            rgb   <= '0;
        end else begin
            de    <= locked && in_win;
            pix_x <= 10'(h_cnt - H_A0);
            pix_y <= v_cnt - V_A0;
            rgb   <= col;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lit_cnt    <= '0;
            frame_lit  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= v_edge;
            if (v_edge) begin
                frame_lit <= lit_cnt;
                lit_cnt   <= '0;
            end else if (de && rgb != 6'd0) begin
                lit_cnt <= lit_cnt + 19'd1;
            end
        end
    end

`ifdef VGA_CAPTURE_CRC_EN
    logic [15:0] crc_acc, crc_q;

    function automatic logic [15:0] crc6(input logic [15:0] c,
                                         input logic [5:0]  d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 5; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_acc <= '0;
            crc_q   <= '0;
        end else if (v_edge) begin
            crc_q   <= crc_acc;
            crc_acc <= 16'hFFFF;
        end else if (de) begin
            crc_acc <= crc6(crc_acc, rgb);
        end
    end

    assign frame_crc = crc_q;
`else
    assign frame_crc = '0;
`endif

endmodule
